// File: rtl/golomb_pkg.sv
// Shared types and defaults for the Golomb ruler search sequencer and its helpers.
// Pure declarations: no latency and no flow control of its own.
package golomb_pkg;

  localparam int NUMPOSITIONS_DEF = 5;
  localparam int VALW_DEF         = 9;
  localparam int LEVELW_DEF       = 7;
  localparam int TIMEOUT_DEF      = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_FOUND  = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_t;

  // Bit offset of mark idx inside a flattened marks vector.
  function automatic int mark_lsb(input int idx, input int valw);
    return idx * valw;
  endfunction

endpackage

// File: rtl/golomb_search_sequencer_if.sv
// Step/verdict bus between the sequencer and the per-mark counter chain.
// One step_valid per request; the counter answers with a single resp_valid strobe, no backpressure.
interface golomb_search_sequencer_if #(
  parameter int VALW   = golomb_pkg::VALW_DEF,
  parameter int LEVELW = golomb_pkg::LEVELW_DEF
);
  logic              step_valid;
  logic [LEVELW-1:0] step_level;
  logic [VALW-1:0]   limit;
  logic              resp_valid;
  logic [VALW-1:0]   resp_val;
  logic              resp_good;
  logic              resp_exhausted;

  modport master (
    output step_valid, step_level, limit,
    input  resp_valid, resp_val, resp_good, resp_exhausted
  );

  modport slave (
    input  step_valid, step_level, limit,
    output resp_valid, resp_val, resp_good, resp_exhausted
  );
endinterface

// File: rtl/golomb_watchdog.sv
// Response watchdog: cleared by load, counts while count is high, expired on the TIMEOUT-th counting cycle.
// Expiry is combinational from the count; no backpressure.
module golomb_watchdog #(
  parameter int TIMEOUT = golomb_pkg::TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = count && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/golomb_search_sequencer.sv
// Golomb search controller: one step request at a time, advance/backtrack/record on each verdict.
// start->step 1 cycle, verdict->step 2 cycles (3 on a found ruler); starts while busy are dropped.
module golomb_search_sequencer
  import golomb_pkg::*;
#(
  parameter int NUMPOSITIONS = NUMPOSITIONS_DEF,
  parameter int VALW         = VALW_DEF,
  parameter int LEVELW       = LEVELW_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [VALW-1:0]                  init_limit,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout,
  golomb_search_sequencer_if.master        bus,
  output logic [(NUMPOSITIONS+1)*VALW-1:0] marks,
  output logic [VALW-1:0]                  best_length,
  output logic [(NUMPOSITIONS+1)*VALW-1:0] best_marks,
  output logic [15:0]                      solutions
);
  localparam int                MW        = (NUMPOSITIONS + 1) * VALW;
  localparam logic [LEVELW-1:0] LVL_FIRST = LEVELW'(1);
  localparam logic [LEVELW-1:0] LVL_LAST  = LEVELW'(NUMPOSITIONS);

  seq_state_t        state_q, state_d;
  logic [LEVELW-1:0] level;
  logic [VALW-1:0]   limit_q;
  logic [VALW-1:0]   r_val;
  logic              r_good, r_exh;
  logic [MW-1:0]     marks_q, best_marks_q;
  logic [VALW-1:0]   best_length_q;
  logic [15:0]       solutions_q;
  logic              timeout_q;
  logic              wd_expired;
  logic              step_valid_c, busy_c, done_c;

  golomb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .load    (state_q == ST_ISSUE),
    .count   (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      // A response arriving on the expiry cycle still counts.
      ST_WAIT: begin
        if (bus.resp_valid)   state_d = ST_EVAL;
        else if (wd_expired)  state_d = ST_FINISH;
      end
      ST_EVAL: begin
        if (r_exh)                           state_d = (level == LVL_FIRST) ? ST_FINISH : ST_ISSUE;
        else if (r_good && level == LVL_LAST) state_d = ST_FOUND;
        else                                 state_d = ST_ISSUE;
      end
      ST_FOUND:  state_d = ST_ISSUE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    step_valid_c = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      ST_ISSUE:                    begin step_valid_c = 1'b1; busy_c = 1'b1; end
      ST_WAIT, ST_EVAL, ST_FOUND:  busy_c = 1'b1;
      ST_FINISH:                   done_c = 1'b1;
      default:                     ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level         <= LVL_FIRST;
      limit_q       <= '0;
      r_val         <= '0;
      r_good        <= 1'b0;
      r_exh         <= 1'b0;
      marks_q       <= '0;
      best_marks_q  <= '0;
      best_length_q <= '0;
      solutions_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            level         <= LVL_FIRST;
            limit_q       <= init_limit;
            marks_q       <= '0;
            best_marks_q  <= '0;
            best_length_q <= '0;
            solutions_q   <= '0;
            timeout_q     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.resp_valid) begin
            r_val  <= bus.resp_val;
            r_good <= bus.resp_good;
            r_exh  <= bus.resp_exhausted;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
          end
        end
        ST_EVAL: begin
          // Mark 0 is never written: level stays within [1, NUMPOSITIONS].
          if (r_exh) begin
            if (level != LVL_FIRST) begin
              marks_q[mark_lsb(int'(level), VALW) +: VALW] <= '0;
              level <= level - LEVELW'(1);
            end
          end else if (r_good) begin
            marks_q[mark_lsb(int'(level), VALW) +: VALW] <= r_val;
            if (level < LVL_LAST) level <= level + LEVELW'(1);
          end
        end
        ST_FOUND: begin
          best_marks_q  <= marks_q;
          best_length_q <= r_val;
          if (solutions_q != 16'hFFFF) solutions_q <= solutions_q + 16'd1;
          limit_q <= (r_val == '0) ? '0 : r_val - VALW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.step_valid = step_valid_c;
  assign bus.step_level = level;
  assign bus.limit      = limit_q;
  assign busy           = busy_c;
  assign done           = done_c;
  assign timeout        = timeout_q;
  assign marks          = marks_q;
  assign best_marks     = best_marks_q;
  assign best_length    = best_length_q;
  assign solutions      = solutions_q;
endmodule

// File: tb/tb_golomb_search_sequencer.sv
// Scoreboarded bench for golomb_search_sequencer with a behavioural counter chain (NUMPOSITIONS=2).
module tb_golomb_search_sequencer;
  localparam int NP = 2;
  localparam int VW = 9;
  localparam int LW = 7;
  localparam int TO = 16;
  localparam int MW = (NP + 1) * VW;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [VW-1:0] init_limit;
  logic          busy, done, timeout;
  logic [MW-1:0] marks, best_marks;
  logic [VW-1:0] best_length;
  logic [15:0]   solutions;

  golomb_search_sequencer_if #(.VALW(VW), .LEVELW(LW)) cbus ();

  golomb_search_sequencer #(
    .NUMPOSITIONS(NP), .VALW(VW), .LEVELW(LW), .TIMEOUT(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .init_limit  (init_limit),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .bus         (cbus),
    .marks       (marks),
    .best_length (best_length),
    .best_marks  (best_marks),
    .solutions   (solutions)
  );

  always #5 clock = ~clock;

  typedef struct { bit fin; bit tmo; int lvl; int lat; } exp_t;
  typedef struct { int len; int lim; logic [MW-1:0] bm; int sol; } fnd_t;

  exp_t exp_q[$];
  fnd_t fnd_q[$];
  int   total, bad;
  int   mm[0:NP];
  int   pos[0:NP];
  int   mlvl, mlimit, msol, sol_seen, lim_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] pack_marks();
    logic [MW-1:0] v;
    v = '0;
    for (int i = 0; i <= NP; i++) v[i*VW +: VW] = VW'(mm[i]);
    return v;
  endfunction

  task automatic check_found();
    fnd_t f;
    if (solutions != 16'(sol_seen)) begin
      sol_seen = int'(solutions);
      chk("found_pending", fnd_q.size() != 0, 1);
      if (fnd_q.size() != 0) begin
        f = fnd_q.pop_front();
        chk("best_length", best_length, f.len);
        chk("found_limit", cbus.limit, f.lim);
        chk("best_marks", best_marks, f.bm);
        chk("solutions", solutions, f.sol);
      end
    end
  endtask

  // Waits (bounded) for the next step request or done pulse and checks it against the scoreboard.
  task automatic observe(input int base);
    int   n;
    bit   hit;
    exp_t e;
    n = 0;
    hit = 0;
    while (!hit && n < 40) begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      check_found();
      hit = cbus.step_valid || done;
    end
    chk("event_seen", hit, 1);
    chk("exp_pending", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("latency", base + n, e.lat);
    if (e.fin) begin
      chk("done", done, 1);
      chk("busy_at_done", busy, 0);
      chk("timeout_flag", timeout, e.tmo);
      @(posedge clock); #1;
      chk("done_pulse", done, 0);
    end else begin
      chk("step_level", cbus.step_level, e.lvl);
      chk("busy", busy, 1);
      chk("timeout_clr", timeout, 0);
      chk("limit", cbus.limit, mlimit);
      chk("limit_mono", cbus.limit <= lim_prev, 1);
      lim_prev = int'(cbus.limit);
      chk("marks", marks, pack_marks());
    end
  endtask

  task automatic do_start(input int lim);
    start      = 1'b1;
    init_limit = VW'(lim);
    for (int i = 0; i <= NP; i++) begin mm[i] = 0; pos[i] = 0; end
    mlvl = 1; mlimit = lim; msol = 0; sol_seen = 0; lim_prev = lim;
    exp_q.push_back('{fin: 0, tmo: 0, lvl: 1, lat: 1});
    observe(0);
  endtask

  task automatic to_wait();
    @(posedge clock); #1;
  endtask

  // Drives one verdict during WAIT and pushes the expected reaction.
  task automatic respond(input int val, input bit good, input bit exh, output bit fin);
    fin = 0;
    cbus.resp_valid     = 1'b1;
    cbus.resp_val       = VW'(val);
    cbus.resp_good      = good;
    cbus.resp_exhausted = exh;
    if (exh) begin
      if (mlvl == 1) begin
        fin = 1;
        exp_q.push_back('{fin: 1, tmo: 0, lvl: 0, lat: 2});
      end else begin
        mm[mlvl] = 0;
        mlvl--;
        exp_q.push_back('{fin: 0, tmo: 0, lvl: mlvl, lat: 2});
      end
    end else if (good) begin
      mm[mlvl] = val;
      if (mlvl < NP) begin
        mlvl++;
        exp_q.push_back('{fin: 0, tmo: 0, lvl: mlvl, lat: 2});
      end else begin
        msol   = (msol == 65535) ? msol : msol + 1;
        mlimit = (val == 0) ? 0 : val - 1;
        fnd_q.push_back('{len: val, lim: mlimit, bm: pack_marks(), sol: msol});
        exp_q.push_back('{fin: 0, tmo: 0, lvl: mlvl, lat: 3});
      end
    end else begin
      exp_q.push_back('{fin: 0, tmo: 0, lvl: mlvl, lat: 2});
    end
    @(posedge clock); #1;
    start               = 1'b0;
    cbus.resp_valid     = 1'b0;
    cbus.resp_good      = 1'b0;
    cbus.resp_exhausted = 1'b0;
    observe(1);
  endtask

  // Behavioural counter at the model's active level: next position above the previous mark.
  task automatic counter_step(output int val, output bit good, output bit exh);
    int m[0:NP];
    int d[$];
    int l;
    l = mlvl;
    if (pos[l] <= mm[l-1]) pos[l] = mm[l-1] + 1;
    else                   pos[l] = pos[l] + 1;
    if (pos[l] > mlimit) begin
      pos[l] = 0; exh = 1; good = 0; val = 0;
    end else begin
      exh = 0; val = pos[l]; good = 1;
      for (int i = 0; i < l; i++) m[i] = mm[i];
      m[l] = pos[l];
      for (int a = 0; a < l; a++)
        for (int b = a + 1; b <= l; b++) d.push_back(m[b] - m[a]);
      for (int i = 0; i < d.size(); i++)
        for (int j = i + 1; j < d.size(); j++)
          if (d[i] == d[j]) good = 0;
    end
  endtask

  initial begin
    bit            fin;
    int            v, it, clashes;
    bit            g, x;
    logic [MW-1:0] bm_017, bm_013;
    bm_017 = {9'd7, 9'd1, 9'd0};
    bm_013 = {9'd3, 9'd1, 9'd0};
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; init_limit = '0;
    cbus.resp_valid = 1'b0; cbus.resp_val = '0;
    cbus.resp_good = 1'b0; cbus.resp_exhausted = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_limit", cbus.limit, 0);
    chk("rst_solutions", solutions, 0);
    chk("rst_step_valid", cbus.step_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_marks", marks, 0);
    reset = 1'b0;

    // Reset while waiting for a verdict; the late verdict must be ignored.
    do_start(10);
    to_wait();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cbus.resp_valid = 1'b1; cbus.resp_good = 1'b1; cbus.resp_val = 9'd5;
    @(posedge clock); #1;
    cbus.resp_valid = 1'b0; cbus.resp_good = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("idle_no_step", cbus.step_valid, 0);
    end
    chk("idle_busy", busy, 0);
    chk("idle_marks", marks, 0);
    chk("idle_limit", cbus.limit, 0);

    // Advance, find {0,1,7}, backtrack, finish; a start while busy is dropped.
    do_start(10);
    to_wait();
    start = 1'b1; init_limit = 9'd3;
    respond(1, 1, 0, fin);
    to_wait(); respond(7, 1, 0, fin);
    to_wait(); respond(0, 0, 1, fin);
    to_wait(); respond(0, 0, 1, fin);
    chk("fin_seen", fin, 1);
    chk("limit_hold", cbus.limit, 6);
    chk("best_length_hold", best_length, 7);
    chk("best_marks_hold", best_marks, bm_017);

    // Watchdog: no verdict at all.
    do_start(10);
    exp_q.push_back('{fin: 1, tmo: 1, lvl: 0, lat: TO + 1});
    observe(0);

    // Full search against the counter model; the first step also shows timeout cleared.
    do_start(10);
    fin = 0; it = 0; clashes = 0;
    while (!fin && it < 100) begin
      counter_step(v, g, x);
      if (!g && !x) clashes++;
      to_wait();
      respond(v, g, x, fin);
      it++;
    end
    chk("search_fin", fin, 1);
    chk("search_best_length", best_length, 3);
    chk("search_best_marks", best_marks, bm_013);
    chk("search_solutions", solutions, msol);
    chk("clash_seen", clashes > 0, 1);
    chk("sb_drained", exp_q.size() + fnd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
